line_walker: RTL

- Forward rasterizer for wireframe lines: accepts one line (two endpoints) and emits every pixel on it as a stream, in Bresenham order from (x0,y0) to (x1,y1).
- Complements the per-pixel edge test. That test asks "is this pixel on the line"; this block produces the on-line pixels directly, for framebuffer or line-buffer writers.
- Line descriptors come in and pixel coordinates go out, each on its own valid/ready handshake.

---
 rtl/line_walker_if.sv | 29 ++
 rtl/line_walker.sv | 110 +++++++++++
 2 files changed

// File: rtl/line_walker_if.sv
// Handshake bundle for line_walker: line descriptor in, pixel stream out.
// Signal suffixes are from the walker's point of view.
interface line_walker_if #(
   parameter int LINE_BITS = 10
);
   logic                 line_valid_i;
   logic                 line_ready_o;
   logic [LINE_BITS-1:0] x0_i;
   logic [LINE_BITS-1:0] y0_i;
   logic [LINE_BITS-1:0] x1_i;
   logic [LINE_BITS-1:0] y1_i;
   logic                 abort_i;
   logic                 pix_valid_o;
   logic                 pix_ready_i;
   logic [LINE_BITS-1:0] pix_x_o;
   logic [LINE_BITS-1:0] pix_y_o;
   logic                 pix_last_o;
   logic                 busy_o;

   modport slave (
      input  line_valid_i, x0_i, y0_i, x1_i, y1_i, abort_i, pix_ready_i,
      output line_ready_o, pix_valid_o, pix_x_o, pix_y_o, pix_last_o, busy_o
   );

   modport master (
      output line_valid_i, x0_i, y0_i, x1_i, y1_i, abort_i, pix_ready_i,
      input  line_ready_o, pix_valid_o, pix_x_o, pix_y_o, pix_last_o, busy_o
   );
endinterface

// File: rtl/line_walker.sv
// Bresenham line rasterizer: takes one line descriptor and streams every pixel
// from (x0,y0) to (x1,y1), one per cycle under continuous downstream ready.
module line_walker #(
   parameter int LINE_BITS = 10
) (
   input  logic          clk_i,
   input  logic          rst_i,
   line_walker_if.slave  bus
);
   localparam int EW = LINE_BITS + 2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_STEP  = 2'd2;

   logic [1:0]            r_state;
   logic [LINE_BITS-1:0]  r_x0, r_y0, r_x1, r_y1;
   logic [LINE_BITS-1:0]  r_dx, r_dy, r_x, r_y;
   logic                  r_sxn, r_syn, r_last;
   logic signed [EW-1:0]  r_err;

   logic [LINE_BITS-1:0]  w_adx, w_ady, w_nx, w_ny, w_cx, w_cy;
   logic signed [EW:0]    w_e2;
   logic signed [EW-1:0]  w_dxs, w_dys, w_nerr;
   logic                  w_stepx, w_stepy, w_valid, w_hs;

   assign w_valid = (r_state == S_STEP);
   assign w_hs    = w_valid && bus.pix_ready_i;

   assign w_adx = (r_x1 >= r_x0) ? r_x1 - r_x0 : r_x0 - r_x1;
   assign w_ady = (r_y1 >= r_y0) ? r_y1 - r_y0 : r_y0 - r_y1;

   // Both axis tests look at the error term before this step's update.
   assign w_e2    = $signed({r_err, 1'b0});
   assign w_stepx = w_e2 >= -$signed({3'b000, r_dy});
   assign w_stepy = w_e2 <= $signed({3'b000, r_dx});
   assign w_dxs   = $signed({2'b00, r_dx});
   assign w_dys   = $signed({2'b00, r_dy});
   assign w_nerr  = r_err - (w_stepx ? w_dys : {EW{1'b0}})
                          + (w_stepy ? w_dxs : {EW{1'b0}});

   assign w_nx = r_sxn ? r_x - LINE_BITS'(1) : r_x + LINE_BITS'(1);
   assign w_ny = r_syn ? r_y - LINE_BITS'(1) : r_y + LINE_BITS'(1);
   assign w_cx = w_stepx ? w_nx : r_x;
   assign w_cy = w_stepy ? w_ny : r_y;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_x0    <= '0;
         r_y0    <= '0;
         r_x1    <= '0;
         r_y1    <= '0;
         r_dx    <= '0;
         r_dy    <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_sxn   <= 1'b0;
         r_syn   <= 1'b0;
         r_last  <= 1'b0;
         r_err   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.line_valid_i) begin
                  r_x0    <= bus.x0_i;
                  r_y0    <= bus.y0_i;
                  r_x1    <= bus.x1_i;
                  r_y1    <= bus.y1_i;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (bus.abort_i) begin
                  r_state <= S_IDLE;
               end else begin
                  r_dx    <= w_adx;
                  r_dy    <= w_ady;
                  r_sxn   <= r_x1 < r_x0;
                  r_syn   <= r_y1 < r_y0;
                  r_err   <= $signed({2'b00, w_adx}) - $signed({2'b00, w_ady});
                  r_x     <= r_x0;
                  r_y     <= r_y0;
                  r_last  <= (r_x0 == r_x1) && (r_y0 == r_y1);
                  r_state <= S_STEP;
               end
            end
            S_STEP: begin
               // An abort coinciding with a handshake still retires that pixel.
               if (bus.abort_i || (w_hs && r_last)) begin
                  r_state <= S_IDLE;
               end else if (w_hs) begin
                  r_err  <= w_nerr;
                  r_x    <= w_cx;
                  r_y    <= w_cy;
                  r_last <= (w_cx == r_x1) && (w_cy == r_y1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.line_ready_o = (r_state == S_IDLE) && !rst_i;
   assign bus.pix_valid_o  = w_valid;
   assign bus.pix_x_o      = r_x;
   assign bus.pix_y_o      = r_y;
   assign bus.pix_last_o   = r_last && w_valid;
   assign bus.busy_o       = (r_state != S_IDLE);
endmodule
